// File: rtl/arm_pipe_pkg.sv
// Shared types for the ARM pipeline control-register bank.
package arm_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 4;

  typedef logic [REG_ADDR_W-1:0] regAddr_t;

  typedef struct packed {
    logic RegWrite;
    logic MemtoReg;
    logic MemWrite;
    logic PCSrc;
    logic Branch;
    logic Valid;
  } ctrl_t;

  typedef struct packed {
    regAddr_t ra1;
    regAddr_t ra2;
    regAddr_t wa3;
    ctrl_t    ctrl;
  } deReg_t;

  // Only the fields still consumed downstream travel past Execute.
  typedef struct packed {
    regAddr_t wa3;
    logic     regWrite;
    logic     memtoReg;
    logic     memWrite;
    logic     pcSrc;
    logic     valid;
  } emReg_t;

  typedef struct packed {
    regAddr_t wa3;
    logic     regWrite;
    logic     memtoReg;
    logic     pcSrc;
    logic     valid;
  } mwReg_t;

endpackage

// File: rtl/pipe_reg.sv
// Generic pipeline boundary register with synchronous reset and clear.
module pipe_reg #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_ctrl_regs.sv
// D/E, E/M and M/W control registers, Execute condition gating, hazard comparators
// and retired-instruction counter.
module pipe_ctrl_regs
  import arm_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] RA1D,
  input  logic [REG_ADDR_W-1:0] RA2D,
  input  logic [REG_ADDR_W-1:0] WA3D,
  input  logic                  RegWriteD,
  input  logic                  MemtoRegD,
  input  logic                  MemWriteD,
  input  logic                  PCSrcD,
  input  logic                  BranchD,
  input  logic                  ValidD,
  input  logic                  FlushE,
  input  logic                  CondExE,
  output logic [REG_ADDR_W-1:0] RA1E,
  output logic [REG_ADDR_W-1:0] RA2E,
  output logic [REG_ADDR_W-1:0] WA3E,
  output logic [REG_ADDR_W-1:0] WA3M,
  output logic [REG_ADDR_W-1:0] WA3W,
  output logic                  RegWriteM,
  output logic                  RegWriteW,
  output logic                  MemtoRegE,
  output logic                  MemtoRegW,
  output logic                  MemWriteM,
  output logic                  PCSrcW,
  output logic                  BranchTakenE,
  output logic                  Match1E_M,
  output logic                  Match1E_W,
  output logic                  Match2E_M,
  output logic                  Match2E_W,
  output logic                  Match12D_E,
  output logic                  PCWrPendingF,
  output logic                  RetireW,
  output logic [CNT_W-1:0]      RetireCount
);

  deReg_t deD, deQ;
  emReg_t emD, emQ;
  mwReg_t mwD, mwQ;

  logic regWriteEg;
  logic memWriteEg;
  logic pcSrcEg;

  always_comb begin
    deD.ra1           = RA1D;
    deD.ra2           = RA2D;
    deD.wa3           = WA3D;
    deD.ctrl.RegWrite = RegWriteD;
    deD.ctrl.MemtoReg = MemtoRegD;
    deD.ctrl.MemWrite = MemWriteD;
    deD.ctrl.PCSrc    = PCSrcD;
    deD.ctrl.Branch   = BranchD;
    deD.ctrl.Valid    = ValidD;
  end

  pipe_reg #(
    .Width($bits(deReg_t))
  ) uDeReg (
    .clk  (clk),
    .reset(reset),
    .clear(FlushE),
    .d    (deD),
    .q    (deQ)
  );

  // A failed condition squashes side effects and validity but keeps WA3 moving.
  assign BranchTakenE = deQ.ctrl.Branch & CondExE;
  assign regWriteEg   = deQ.ctrl.RegWrite & CondExE;
  assign memWriteEg   = deQ.ctrl.MemWrite & CondExE;
  assign pcSrcEg      = (deQ.ctrl.PCSrc & CondExE) | BranchTakenE;

  always_comb begin
    emD.wa3      = deQ.wa3;
    emD.regWrite = regWriteEg;
    emD.memtoReg = deQ.ctrl.MemtoReg;
    emD.memWrite = memWriteEg;
    emD.pcSrc    = pcSrcEg;
    emD.valid    = deQ.ctrl.Valid & CondExE;
  end

  pipe_reg #(
    .Width($bits(emReg_t))
  ) uEmReg (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (emD),
    .q    (emQ)
  );

  always_comb begin
    mwD.wa3      = emQ.wa3;
    mwD.regWrite = emQ.regWrite;
    mwD.memtoReg = emQ.memtoReg;
    mwD.pcSrc    = emQ.pcSrc;
    mwD.valid    = emQ.valid;
  end

  pipe_reg #(
    .Width($bits(mwReg_t))
  ) uMwReg (
    .clk  (clk),
    .reset(reset),
    .clear(1'b0),
    .d    (mwD),
    .q    (mwQ)
  );

  assign RA1E      = deQ.ra1;
  assign RA2E      = deQ.ra2;
  assign WA3E      = deQ.wa3;
  assign MemtoRegE = deQ.ctrl.MemtoReg;
  assign WA3M      = emQ.wa3;
  assign RegWriteM = emQ.regWrite;
  assign MemWriteM = emQ.memWrite;
  assign WA3W      = mwQ.wa3;
  assign RegWriteW = mwQ.regWrite;
  assign MemtoRegW = mwQ.memtoReg;
  assign PCSrcW    = mwQ.pcSrc;
  assign RetireW   = mwQ.valid;

  // Unqualified matches; the hazard unit ANDs in RegWrite/MemtoReg.
  assign Match1E_M  = (deQ.ra1 == emQ.wa3);
  assign Match1E_W  = (deQ.ra1 == mwQ.wa3);
  assign Match2E_M  = (deQ.ra2 == emQ.wa3);
  assign Match2E_W  = (deQ.ra2 == mwQ.wa3);
  assign Match12D_E = (RA1D == deQ.wa3) | (RA2D == deQ.wa3);

  assign PCWrPendingF = PCSrcD | pcSrcEg | emQ.pcSrc;

  always_ff @(posedge clk) begin
    if (reset) begin
      RetireCount <= '0;
    end else if (mwQ.valid) begin
      RetireCount <= RetireCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Scoreboard bench for pipe_ctrl_regs: timed expectations plus a retire-order queue.
module tb_pipe_ctrl_regs;

  localparam int unsigned CntW = 4;

  localparam logic [5:0] CRw = 6'b100000;
  localparam logic [5:0] CMr = 6'b010000;
  localparam logic [5:0] CMw = 6'b001000;
  localparam logic [5:0] CPs = 6'b000100;
  localparam logic [5:0] CBr = 6'b000010;
  localparam logic [5:0] CVd = 6'b000001;

  typedef enum int {
    SRa1E, SRa2E, SWa3E, SWa3M, SWa3W, SRegWriteM, SRegWriteW, SMemtoRegE, SMemtoRegW,
    SMemWriteM, SPCSrcW, SBranchTakenE, SMatch1E_M, SMatch1E_W, SMatch2E_M, SMatch2E_W,
    SMatch12D_E, SPCWrPendingF, SRetireW, SRetireCount
  } sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } chk_t;

  logic            clk;
  logic            reset;
  logic [3:0]      RA1D, RA2D, WA3D;
  logic            RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, ValidD;
  logic            FlushE, CondExE;
  logic [3:0]      RA1E, RA2E, WA3E, WA3M, WA3W;
  logic            RegWriteM, RegWriteW, MemtoRegE, MemtoRegW, MemWriteM, PCSrcW;
  logic            BranchTakenE;
  logic            Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E;
  logic            PCWrPendingF, RetireW;
  logic [CntW-1:0] RetireCount;

  int         cyc = 0;
  int         nChecks = 0;
  int         nFail = 0;
  logic       endReq = 1'b0;
  chk_t       checkQ[$];
  logic [3:0] retireQ[$];
  logic       pendValid = 1'b0;
  logic [3:0] pendWa3 = '0;

  pipe_ctrl_regs #(
    .CNT_W(CntW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .RA1D        (RA1D),
    .RA2D        (RA2D),
    .WA3D        (WA3D),
    .RegWriteD   (RegWriteD),
    .MemtoRegD   (MemtoRegD),
    .MemWriteD   (MemWriteD),
    .PCSrcD      (PCSrcD),
    .BranchD     (BranchD),
    .ValidD      (ValidD),
    .FlushE      (FlushE),
    .CondExE     (CondExE),
    .RA1E        (RA1E),
    .RA2E        (RA2E),
    .WA3E        (WA3E),
    .WA3M        (WA3M),
    .WA3W        (WA3W),
    .RegWriteM   (RegWriteM),
    .RegWriteW   (RegWriteW),
    .MemtoRegE   (MemtoRegE),
    .MemtoRegW   (MemtoRegW),
    .MemWriteM   (MemWriteM),
    .PCSrcW      (PCSrcW),
    .BranchTakenE(BranchTakenE),
    .Match1E_M   (Match1E_M),
    .Match1E_W   (Match1E_W),
    .Match2E_M   (Match2E_M),
    .Match2E_W   (Match2E_W),
    .Match12D_E  (Match12D_E),
    .PCWrPendingF(PCWrPendingF),
    .RetireW     (RetireW),
    .RetireCount (RetireCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sigVal(input sig_e s);
    case (s)
      SRa1E:         return 32'(RA1E);
      SRa2E:         return 32'(RA2E);
      SWa3E:         return 32'(WA3E);
      SWa3M:         return 32'(WA3M);
      SWa3W:         return 32'(WA3W);
      SRegWriteM:    return 32'(RegWriteM);
      SRegWriteW:    return 32'(RegWriteW);
      SMemtoRegE:    return 32'(MemtoRegE);
      SMemtoRegW:    return 32'(MemtoRegW);
      SMemWriteM:    return 32'(MemWriteM);
      SPCSrcW:       return 32'(PCSrcW);
      SBranchTakenE: return 32'(BranchTakenE);
      SMatch1E_M:    return 32'(Match1E_M);
      SMatch1E_W:    return 32'(Match1E_W);
      SMatch2E_M:    return 32'(Match2E_M);
      SMatch2E_W:    return 32'(Match2E_W);
      SMatch12D_E:   return 32'(Match12D_E);
      SPCWrPendingF: return 32'(PCWrPendingF);
      SRetireW:      return 32'(RetireW);
      default:       return 32'(RetireCount);
    endcase
  endfunction

  // Expect signal s to equal exp dc cycles from now.
  task automatic chk(input int dc, input sig_e s, input logic [31:0] exp, input string name);
    chk_t e;
    e.cyc  = cyc + dc;
    e.sig  = s;
    e.exp  = exp;
    e.name = name;
    checkQ.push_back(e);
  endtask

  // Apply D-stage inputs for one cycle and predict which instruction retires.
  task automatic drive(input logic [3:0] ra1, input logic [3:0] ra2, input logic [3:0] wa3,
                       input logic [5:0] c, input logic flush, input logic cond,
                       input logic rst);
    RA1D  = ra1;
    RA2D  = ra2;
    WA3D  = wa3;
    {RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD, ValidD} = c;
    FlushE  = flush;
    CondExE = cond;
    reset   = rst;
    if (rst) begin
      pendValid = 1'b0;
    end else begin
      if (pendValid && cond) retireQ.push_back(pendWa3);
      pendValid = !flush && c[0];
      pendWa3   = wa3;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (reset) retireQ.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  always @(negedge clk) begin
    logic [31:0] got;
    logic [3:0]  expWa3;
    for (int i = checkQ.size() - 1; i >= 0; i--) begin
      if (checkQ[i].cyc == cyc) begin
        nChecks++;
        got = sigVal(checkQ[i].sig);
        if (got !== checkQ[i].exp) begin
          nFail++;
          $display("FAIL %s @cycle %0d: got %0h, expected %0h", checkQ[i].name, cyc, got,
                   checkQ[i].exp);
        end
        checkQ.delete(i);
      end
    end
    if (RetireW === 1'b1) begin
      nChecks++;
      if (retireQ.size() == 0) begin
        nFail++;
        $display("FAIL retire_unexpected @cycle %0d: got WA3W=%0h, expected no retire", cyc,
                 WA3W);
      end else begin
        expWa3 = retireQ.pop_front();
        if (WA3W !== expWa3) begin
          nFail++;
          $display("FAIL retire_wa3 @cycle %0d: got %0h, expected %0h", cyc, WA3W, expWa3);
        end
      end
    end
    if (endReq) begin
      nChecks++;
      if (checkQ.size() != 0) begin
        nFail++;
        $display("FAIL pending_checks: got %0d unresolved, expected 0", checkQ.size());
      end
      nChecks++;
      if (retireQ.size() != 0) begin
        nFail++;
        $display("FAIL missing_retire: got %0d outstanding, expected 0", retireQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
    end
  end

  initial begin
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    tick();
    tick();

    // Reset then idle
    idle(2);
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(0, SRegWriteM, 0, "rst_RegWriteM");
    chk(0, SRegWriteW, 0, "rst_RegWriteW");
    chk(0, SMemtoRegE, 0, "rst_MemtoRegE");
    chk(0, SMemtoRegW, 0, "rst_MemtoRegW");
    chk(0, SMemWriteM, 0, "rst_MemWriteM");
    chk(0, SPCSrcW, 0, "rst_PCSrcW");
    chk(0, SBranchTakenE, 0, "rst_BranchTakenE");
    chk(0, SPCWrPendingF, 0, "rst_PCWrPendingF");
    chk(0, SRetireW, 0, "rst_RetireW");
    chk(0, SRetireCount, 0, "rst_RetireCount");
    chk(0, SMatch1E_M, 1, "rst_Match1E_M");
    chk(0, SMatch1E_W, 1, "rst_Match1E_W");
    chk(0, SMatch2E_M, 1, "rst_Match2E_M");
    chk(0, SMatch2E_W, 1, "rst_Match2E_W");
    chk(0, SMatch12D_E, 1, "rst_Match12D_E");
    tick();

    // Producer r3 followed by two consumers of r3 on port 1
    drive(4'd0, 4'd0, 4'd3, CRw | CVd, 1'b0, 1'b1, 1'b0);
    chk(2, SMatch1E_M, 1, "fwd_Match1E_M");
    chk(2, SRegWriteM, 1, "fwd_RegWriteM");
    chk(2, SWa3M, 3, "fwd_WA3M");
    chk(2, SRa1E, 3, "fwd_RA1E");
    chk(3, SMatch1E_W, 1, "fwd_Match1E_W");
    chk(3, SRegWriteW, 1, "fwd_RegWriteW");
    chk(3, SMatch1E_M, 0, "fwd_Match1E_M_clear");
    chk(3, SWa3W, 3, "fwd_WA3W");
    tick();
    drive(4'd3, 4'd0, 4'd0, CVd, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd3, 4'd0, 4'd0, CVd, 1'b0, 1'b1, 1'b0);
    tick();
    idle(3);
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(0, SRetireCount, 3, "count_after_fwd");
    tick();

    // Producer r6 followed by consumers of r6 on port 2
    drive(4'd0, 4'd0, 4'd6, CRw | CVd, 1'b0, 1'b1, 1'b0);
    chk(2, SMatch2E_M, 1, "fwd2_Match2E_M");
    chk(2, SRa2E, 6, "fwd2_RA2E");
    chk(2, SMatch1E_M, 0, "fwd2_Match1E_M");
    chk(3, SMatch2E_W, 1, "fwd2_Match2E_W");
    chk(3, SMatch2E_M, 0, "fwd2_Match2E_M_clear");
    tick();
    drive(4'd0, 4'd6, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 4'd6, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    idle(3);

    // Load-use detection, then flush of the dependent instruction
    drive(4'd0, 4'd0, 4'd5, CRw | CMr | CVd, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 4'd5, 4'd0, CVd, 1'b1, 1'b1, 1'b0);
    chk(0, SMatch12D_E, 1, "load_Match12D_E");
    chk(0, SMemtoRegE, 1, "load_MemtoRegE");
    chk(1, SMemtoRegE, 0, "flush_MemtoRegE");
    chk(1, SWa3E, 0, "flush_WA3E");
    chk(1, SMatch12D_E, 0, "flush_Match12D_E");
    chk(2, SMemtoRegW, 1, "load_MemtoRegW");
    chk(2, SWa3W, 5, "load_WA3W");
    chk(3, SRetireW, 0, "flush_bubble_RetireW");
    tick();
    drive(4'd7, 4'd9, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    tick();
    idle(3);

    // Taken branch
    drive(4'd0, 4'd0, 4'd0, CBr | CVd, 1'b0, 1'b1, 1'b0);
    chk(0, SPCWrPendingF, 0, "br_D_PCWrPendingF");
    tick();
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(0, SBranchTakenE, 1, "br_BranchTakenE");
    chk(0, SPCWrPendingF, 1, "br_E_PCWrPendingF");
    chk(1, SPCWrPendingF, 1, "br_M_PCWrPendingF");
    chk(1, SBranchTakenE, 0, "br_BranchTakenE_next");
    chk(2, SPCSrcW, 1, "br_PCSrcW");
    tick();
    idle(3);

    // Not-taken branch
    drive(4'd0, 4'd0, 4'd0, CBr | CVd, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk(0, SBranchTakenE, 0, "nt_BranchTakenE");
    chk(0, SPCWrPendingF, 0, "nt_E_PCWrPendingF");
    chk(1, SPCWrPendingF, 0, "nt_M_PCWrPendingF");
    chk(2, SPCSrcW, 0, "nt_PCSrcW");
    chk(2, SRetireW, 0, "nt_RetireW");
    tick();
    idle(3);

    // PC write plus store, squashed by condition; WA3 still travels
    drive(4'd0, 4'd0, 4'd4, CPs | CMw | CVd, 1'b0, 1'b1, 1'b0);
    chk(0, SPCWrPendingF, 1, "pcD_PCWrPendingF");
    tick();
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    chk(0, SPCWrPendingF, 0, "squash_PCWrPendingF");
    chk(1, SMemWriteM, 0, "squash_MemWriteM");
    chk(1, SWa3M, 4, "squash_WA3M");
    tick();
    idle(3);

    // Store with condition passing
    drive(4'd0, 4'd0, 4'd9, CMw | CVd, 1'b0, 1'b1, 1'b0);
    tick();
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(1, SMemWriteM, 1, "store_MemWriteM");
    tick();
    idle(3);

    // Fresh reset, then 10 back-to-back valid instructions
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(4'd0, 4'd0, 4'(i), CRw | CVd, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(2, SRetireCount, 9, "stream_count_9");
    chk(3, SRetireCount, 10, "stream_count_10");
    tick();
    idle(4);

    // Reset lands in the middle of a stream
    for (int i = 0; i < 5; i++) begin
      drive(4'd0, 4'd0, 4'(i + 1), CVd, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(4'd0, 4'd0, 4'd7, CVd, 1'b0, 1'b1, 1'b1);
    chk(0, SRetireCount, 12, "midrst_count_before");
    chk(1, SRetireCount, 0, "midrst_count_after");
    chk(1, SRetireW, 0, "midrst_RetireW");
    chk(2, SRetireW, 0, "midrst_RetireW_next");
    tick();
    idle(4);

    // 17 retirements through a 4-bit counter
    for (int i = 0; i < 17; i++) begin
      drive(4'd0, 4'd0, 4'(i), CVd, 1'b0, 1'b1, 1'b0);
      tick();
    end
    drive(4'd0, 4'd0, 4'd0, 6'd0, 1'b0, 1'b1, 1'b0);
    chk(2, SRetireCount, 0, "wrap_count_16");
    chk(3, SRetireCount, 1, "wrap_count_17");
    tick();
    idle(4);

    endReq = 1'b1;
  end

endmodule

// File: doc/pipe_ctrl_regs.md
# pipe_ctrl_regs

Pipeline control-register bank for the 5-stage ARM core. It carries register addresses and control bits through the Decode→Execute, Execute→Memory and Memory→Writeback boundaries, and applies the hazard unit's FlushE to the D/E register. It generates the comparison and pending-write signals the hazard unit consumes: Match*, PCWrPendingF, BranchTakenE, RegWriteM/W, MemtoRegE, PCSrcW. It also keeps per-stage valid bits and a retired-instruction counter for the bench and debug.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  core clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears all state
- RA1D, RA2D, WA3D  in  4 each  decode-stage source/destination register numbers
- RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD  in  1 each  decode-stage control bits
- ValidD  in  1  decode stage holds a real instruction
- FlushE  in  1  from hazard unit; bubble into Execute
- CondExE  in  1  from condition unit; Execute instruction's condition passes
- RA1E, RA2E, WA3E, WA3M, WA3W  out  4 each  registered addresses
- RegWriteM, RegWriteW, MemtoRegE, MemtoRegW, MemWriteM, PCSrcW  out  1 each  registered or gated control
- BranchTakenE  out  1  BranchE & CondExE
- Match1E_M, Match1E_W, Match2E_M, Match2E_W, Match12D_E  out  1 each  address comparisons
- PCWrPendingF  out  1  a PC write is in flight in D, E or M
- RetireW  out  1  valid instruction in Writeback this cycle
- RetireCount  out  CNT_W  number of instructions retired since reset

## Operation
- D/E register captures RA1D, RA2D, WA3D, RegWriteD, MemtoRegD, MemWriteD, PCSrcD, BranchD and ValidD every cycle.
- When FlushE=1, the D/E register loads all zeros, addresses included.
- Execute gating is combinational:
  - RegWriteEg = RegWriteE & CondExE
  - MemWriteEg = MemWriteE & CondExE
  - PCSrcEg = (PCSrcE & CondExE) | BranchTakenE
  - BranchTakenE = BranchE & CondExE
- E/M register captures WA3E, RegWriteEg, MemtoRegE, MemWriteEg, PCSrcEg and ValidE & CondExE.
- M/W register captures WA3M, RegWriteM, MemtoRegM, PCSrcM and ValidM.
- E/M and M/W are never flushed or stalled. The upstream F/D register owns StallD and FlushD.
- Comparisons are combinational, 4-bit equality:
  - Match1E_M = (RA1E==WA3M), Match1E_W = (RA1E==WA3W)
  - Match2E_M = (RA2E==WA3M), Match2E_W = (RA2E==WA3W)
  - Match12D_E = (RA1D==WA3E) | (RA2D==WA3E)
- Match outputs are unqualified. The hazard unit qualifies them with RegWrite/MemtoReg.
- PCWrPendingF = PCSrcD | PCSrcEg | PCSrcM.
- RetireW = ValidW.
- RetireCount increments by 1 when ValidW=1 and wraps modulo 2^CNT_W.

## Timing
- Register latency is one cycle per boundary: a D-stage bit appears in E one edge later, in M two, in W three.
- Reset has priority over FlushE. On the reset edge every register and RetireCount go to 0.
- After reset, with D inputs at 0:
  - all control outputs, BranchTakenE, PCWrPendingF and RetireW are 0
  - all addresses are 0, so every Match* is 1; this is harmless because all RegWrite/MemtoReg are 0
- FlushE together with valid D inputs: the D instruction is discarded and E holds a bubble the next cycle. M and W still advance normally.
- CondExE=0 squashes the E instruction's side effects and its valid bit at the E/M boundary. WA3 is still propagated.
- Counter wrap: RetireCount=2^CNT_W−1 with ValidW=1 gives 0 next cycle.
- Reset asserted mid-stream drops all in-flight instructions. No retire is counted on the reset edge.

## Structure
- Shared package `arm_pipe_pkg`: REG_ADDR_W=4 and a packed `ctrl_t` struct {RegWrite, MemtoReg, MemWrite, PCSrc, Branch, Valid}.
- One sub-module, `pipe_reg`: parameterised width, synchronous reset plus synchronous clear, instantiated three times.
- Comparators, gating and the counter stay at top level.

## Test plan
- Reset, then 3 idle cycles → all control outputs 0, all Match* 1, RetireCount 0.
- Inject WA3D=3, RegWriteD=1, CondExE=1, then on the next instruction RA1D=3 → Match1E_M=1 and RegWriteM=1 in the same cycle; the following cycle Match1E_W=1 and RegWriteW=1.
- Load with MemtoRegD=1, WA3D=5, followed by RA2D=5 in D → Match12D_E=1 and MemtoRegE=1. Pulse FlushE → next cycle MemtoRegE=0, WA3E=0, ValidE=0.
- BranchD=1 with CondExE=1 → BranchTakenE=1 and PCWrPendingF=1. PCSrcW=1 two cycles later. With CondExE=0 → BranchTakenE=0, and PCSrcM/PCSrcW stay 0.
- Stream of 10 valid instructions with CondExE=1, no flush → RetireCount=10 three cycles after the last enters E. Assert reset mid-stream → RetireCount=0 and RetireW=0 next cycle.
- CNT_W=4, 17 retirements → RetireCount=1 (wrap).
